enigma_out_buffer: RTL and testbench



---
 rtl/enigma_out_buffer_if.sv | 28 ++
 rtl/enigma_out_buffer.sv | 127 ++++++++++++
 tb/tb_enigma_out_buffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/enigma_out_buffer_if.sv
// Core-to-host port bundle of the enigma output buffer: letter push side, flush,
// the 4-phase req/ack pins toward the host, and the status outputs.
interface enigma_out_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          in_valid;
    logic [4:0]    in_char;
    logic          in_ready;
    logic          flush;
    logic [5:0]    out_data;
    logic          out_valid;
    logic          out_ack;
    logic [AW:0]   count;
    logic          bad_char;

    // Driver side: core and host environment around the buffer.
    modport master (
        output in_valid, in_char, flush, out_ack,
        input  in_ready, out_data, out_valid, count, bad_char
    );

    modport slave (
        input  in_valid, in_char, flush, out_ack,
        output in_ready, out_data, out_valid, count, bad_char
    );
endinterface

// File: rtl/enigma_out_buffer.sv
// Enigma output buffer: FIFO of enciphered letters presented to an off-chip host via 4-phase
// req/ack. Optional 5-letter grouping with separators is enabled by ENIGMA_GROUP5_EN.
module enigma_out_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    enigma_out_buffer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [5:0] SepCode = 6'b100000;

    typedef enum logic [1:0] {StIdle, StPresent, StWaitLow} state_e;

    logic [4:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          bad_char_q;
    logic          ack_meta_q, ack_s_q;
    state_e        state_q;
    logic          out_valid_q;
    logic [5:0]    out_data_q;

    logic full, empty, push, push_good, load, sep_due, pop;

    assign full      = (count_q == DEPTH[AW:0]);
    assign empty     = (count_q == '0);
    assign bus.in_ready = ~full & ~bus.flush;
    assign push      = bus.in_valid & bus.in_ready;
    assign push_good = push & (bus.in_char <= 5'd25);

    // A flush cycle never loads the output register, so the host sees no stale letter.
    assign load = (state_q == StIdle) & ~empty & ~bus.flush;
    assign pop  = load & ~sep_due;

`ifdef ENIGMA_GROUP5_EN
    logic [2:0] group_q;
    assign sep_due = (group_q == 3'd5);
`else
    assign sep_due = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            bad_char_q <= 1'b0;
        end else begin
            if (push && !push_good) begin
                bad_char_q <= 1'b1;
            end
            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_good) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + {{AW{1'b0}}, push_good} - {{AW{1'b0}}, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_good) begin
            mem_q[wr_ptr_q] <= bus.in_char;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= bus.out_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef ENIGMA_GROUP5_EN
            group_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StPresent;
                        out_data_q  <= sep_due ? SepCode : {1'b0, mem_q[rd_ptr_q]};
                    end
                end
                StPresent: begin
                    if (ack_s_q) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StWaitLow;
                    end
                end
                StWaitLow: begin
                    if (!ack_s_q) state_q <= StIdle;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
`ifdef ENIGMA_GROUP5_EN
            // Counts letters since the last separator; a separator resets it.
            if (bus.flush) begin
                group_q <= '0;
            end else if (load) begin
                group_q <= sep_due ? 3'd0 : group_q + 3'd1;
            end
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.count     = count_q;
    assign bus.bad_char  = bad_char_q;
endmodule

// File: tb/tb_enigma_out_buffer.sv
// Self-checking bench for enigma_out_buffer: directed vector table, handshake/reset
// sequences, and letter streams against a host model with random ack delays.
module tb_enigma_out_buffer;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    enigma_out_buffer_if #(.DEPTH(DEPTH)) bus ();

    enigma_out_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int max_cnt = 0;

    logic [4:0] letters[$];
    logic [5:0] exp_q[$];

    always @(negedge clk) begin
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_char  = '0;
        bus.flush    = 1'b0;
        bus.out_ack  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive_stream(input bit rnd);
        int w;
        for (int i = 0; i < letters.size(); i++) begin
            if (rnd) repeat ($urandom_range(0, 6)) tick();
            bus.in_valid = 1'b1;
            bus.in_char  = letters[i];
            w = 0;
            @(negedge clk);
            while (!bus.in_ready && w < 1000) begin
                @(negedge clk);
                w++;
            end
            if (!bus.in_ready) begin
                check("stream_ready_timeout", int'(bus.in_ready), 1);
                bus.in_valid = 1'b0;
                break;
            end
            tick();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic host_stream();
        int w;
        for (int k = 0; k < exp_q.size(); k++) begin
            w = 0;
            @(negedge clk);
            while (!bus.out_valid && w < 3000) begin
                @(negedge clk);
                w++;
            end
            if (!bus.out_valid) begin
                check("stream_req_timeout", int'(bus.out_valid), 1);
                break;
            end
            check("stream_data", int'(bus.out_data), int'(exp_q[k]));
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1 bus.out_ack = 1'b1;
            w = 0;
            while (bus.out_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (bus.out_valid) begin
                check("stream_ack_timeout", int'(bus.out_valid), 0);
                break;
            end
            @(posedge clk);
            #1 bus.out_ack = 1'b0;
        end
    endtask

    task automatic run_stream(input int n, input bit rnd);
        letters.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            letters.push_back(rnd ? 5'($urandom_range(0, 25)) : 5'((i * 7 + 3) % 26));
            exp_q.push_back({1'b0, letters[i]});
`ifdef ENIGMA_GROUP5_EN
            if ((i % 5) == 4 && i != n - 1) exp_q.push_back(6'b100000);
`endif
        end
        fork
            drive_stream(rnd);
            host_stream();
        join
        repeat (10) tick();
        check("stream_no_extra_valid", int'(bus.out_valid), 0);
        check("stream_count_empty", int'(bus.count), 0);
    endtask

    typedef struct packed {
        logic       v;
        logic [4:0] c;
        logic       fl;
        logic       rdy;
        logic [2:0] cnt;
        logic       ov;
        logic [5:0] od;
        logic       bad;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // Host stalled (ack=0): fill, bad code, full back-pressure, flush with push.
        vecs[0] = '{1'b1, 5'd7,  1'b0, 1'b1, 3'd1, 1'b0, 6'd0, 1'b0};
        vecs[1] = '{1'b1, 5'd1,  1'b0, 1'b1, 3'd1, 1'b1, 6'd7, 1'b0};
        vecs[2] = '{1'b1, 5'd2,  1'b0, 1'b1, 3'd2, 1'b1, 6'd7, 1'b0};
        vecs[3] = '{1'b1, 5'd30, 1'b0, 1'b1, 3'd2, 1'b1, 6'd7, 1'b1};
        vecs[4] = '{1'b1, 5'd3,  1'b0, 1'b1, 3'd3, 1'b1, 6'd7, 1'b1};
        vecs[5] = '{1'b1, 5'd4,  1'b0, 1'b1, 3'd4, 1'b1, 6'd7, 1'b1};
        vecs[6] = '{1'b1, 5'd5,  1'b0, 1'b0, 3'd4, 1'b1, 6'd7, 1'b1};
        vecs[7] = '{1'b1, 5'd5,  1'b1, 1'b0, 3'd0, 1'b1, 6'd7, 1'b1};
        vecs[8] = '{1'b0, 5'd0,  1'b0, 1'b1, 3'd0, 1'b1, 6'd7, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_char  = '0;
        bus.flush    = 1'b0;
        bus.out_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("reset_count", int'(bus.count), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_data", int'(bus.out_data), 0);
        check("reset_bad_char", int'(bus.bad_char), 0);
        check("reset_in_ready", int'(bus.in_ready), 1);

        for (int i = 0; i < 9; i++) begin
            bus.in_valid = vecs[i].v;
            bus.in_char  = vecs[i].c;
            bus.flush    = vecs[i].fl;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i), int'(bus.in_ready), int'(vecs[i].rdy));
            tick();
            check($sformatf("vec%0d_count", i), int'(bus.count), int'(vecs[i].cnt));
            check($sformatf("vec%0d_out_valid", i), int'(bus.out_valid), int'(vecs[i].ov));
            check($sformatf("vec%0d_out_data", i), int'(bus.out_data), int'(vecs[i].od));
            check($sformatf("vec%0d_bad_char", i), int'(bus.bad_char), int'(vecs[i].bad));
        end

        // Letter 7 still presented after the flush; finish its handshake.
        bus.out_ack = 1'b1;
        tick();
        check("ack_edge1_valid", int'(bus.out_valid), 1);
        tick();
        check("ack_edge2_valid", int'(bus.out_valid), 1);
        tick();
        check("ack_edge3_valid", int'(bus.out_valid), 0);
        bus.out_ack = 1'b0;
        repeat (5) tick();
        check("post_flush_no_req", int'(bus.out_valid), 0);
        check("post_flush_data_hold", int'(bus.out_data), 7);
        check("post_flush_count", int'(bus.count), 0);

        // Single-letter latency, then asynchronous reset mid-handshake.
        bus.in_valid = 1'b1;
        bus.in_char  = 5'd9;
        tick();
        bus.in_valid = 1'b0;
        check("lat_n1_count", int'(bus.count), 1);
        check("lat_n1_valid", int'(bus.out_valid), 0);
        tick();
        check("lat_n2_valid", int'(bus.out_valid), 1);
        check("lat_n2_data", int'(bus.out_data), 9);
        check("lat_n2_count", int'(bus.count), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(bus.out_valid), 0);
        check("async_rst_data", int'(bus.out_data), 0);
        check("async_rst_count", int'(bus.count), 0);
        check("async_rst_bad", int'(bus.bad_char), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_stream(12, 1'b0);
        do_reset();
        run_stream(24, 1'b1);
        check("max_count_within_depth", int'(max_cnt <= DEPTH), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
